// File: rtl/dram_arbiter_if.sv
// dram_arbiter_if: bundles the CPU, VGA and DRAM-controller signals of the
// DRAM arbiter. The slave modport is the arbiter's own view. The master
// modport is the surrounding system: both requesters plus the controller.
interface dram_arbiter_if;
  logic        cpu_req;
  logic [24:0] cpu_addr;
  logic        cpu_write_en;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        vga_req;
  logic [24:0] vga_addr;
  logic        vga_word_valid;
  logic [4:0]  vga_word_idx;
  logic [15:0] vga_rdata;
  logic        vga_done;
  logic        dram_start;
  logic [24:0] dram_addr;
  logic        dram_write_en;
  logic        dram_burst_en;
  logic [15:0] dram_data_in;
  logic [15:0] dram_read_data;
  logic        dram_data_ready;
  logic        owner;
  logic        busy;
  logic        timeout_err;

  modport slave (
    input  cpu_req, cpu_addr, cpu_write_en, cpu_wdata,
    input  vga_req, vga_addr,
    input  dram_read_data, dram_data_ready,
    output cpu_ack, cpu_rdata,
    output vga_word_valid, vga_word_idx, vga_rdata, vga_done,
    output dram_start, dram_addr, dram_write_en, dram_burst_en, dram_data_in,
    output owner, busy, timeout_err
  );

  modport master (
    output cpu_req, cpu_addr, cpu_write_en, cpu_wdata,
    output vga_req, vga_addr,
    output dram_read_data, dram_data_ready,
    input  cpu_ack, cpu_rdata,
    input  vga_word_valid, vga_word_idx, vga_rdata, vga_done,
    input  dram_start, dram_addr, dram_write_en, dram_burst_en, dram_data_in,
    input  owner, busy, timeout_err
  );
endinterface

// File: rtl/dram_arbiter.sv
// dram_arbiter: shares the single SDRAM controller port between the CPU
// memory-map path (single-word reads/writes) and the VGA line fetcher
// (BURST_LEN-word read bursts). VGA has fixed priority, but may take at most
// VGA_MAX_CONSEC back-to-back grants while the CPU is waiting.
// Optional WAIT-state timeout: define DRAM_ARB_TIMEOUT_EN.
module dram_arbiter #(
  parameter int BURST_LEN      = 32,
  parameter int VGA_MAX_CONSEC = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  dram_arbiter_if.slave bus
);

  localparam int              CW            = (VGA_MAX_CONSEC < 1) ? 1 : $clog2(VGA_MAX_CONSEC + 1);
  localparam logic [CW-1:0]   CONSEC_MAX    = CW'(VGA_MAX_CONSEC);
  localparam logic [4:0]      LAST_WORD     = 5'(BURST_LEN - 1);
  localparam logic [15:0]     TIMEOUT_RDATA = 16'hDEAD;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic          owner_q;
  logic [CW-1:0] consec;
  logic [4:0]    word_cnt;
  logic [24:0]   lat_addr;
  logic          lat_we;
  logic [15:0]   lat_wdata;
  logic [15:0]   rdata_q;
  logic          grant_vga;
  logic          grant_cpu;
  logic          word_hit;
  logic          last_word;
  logic          burst_end;
  logic          timeout_hit;
  logic          active;

  // A completed word only counts in WAIT; a CPU transaction is one word long.
  assign word_hit  = (state == ST_WAIT) && bus.dram_data_ready;
  assign last_word = !owner_q || (word_cnt == LAST_WORD);
  assign burst_end = word_hit && last_word;

`ifdef DRAM_ARB_TIMEOUT_EN
  localparam int            TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] WAIT_LIMIT = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] wait_cnt;
  logic          timeout_q;

  assign timeout_hit = (state == ST_WAIT) && !burst_end && (wait_cnt == WAIT_LIMIT);

  // Count WAIT cycles of the current transaction and remember any timeout.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state != ST_WAIT) wait_cnt <= '0;
      else                  wait_cnt <= wait_cnt + 1'b1;
      if (timeout_hit) timeout_q <= 1'b1;
    end
  end

  assign bus.timeout_err = timeout_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout_hit     = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  // Arbitrate in IDLE and select the next transaction phase.
  always_comb begin
    state_next = state;
    grant_vga  = 1'b0;
    grant_cpu  = 1'b0;
    case (state)
      ST_IDLE: begin
        grant_vga = bus.vga_req && (!bus.cpu_req || (consec < CONSEC_MAX));
        grant_cpu = !grant_vga && bus.cpu_req;
        if (grant_vga || grant_cpu) state_next = ST_ISSUE;
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (burst_end || timeout_hit) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State register; reset discards any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Latch the winning request and track the VGA streak against a waiting CPU.
  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q   <= 1'b0;
      consec    <= '0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
    end else if (grant_vga) begin
      owner_q   <= 1'b1;
      lat_addr  <= bus.vga_addr;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      consec    <= bus.cpu_req ? consec + 1'b1 : '0;
    end else if (grant_cpu) begin
      owner_q   <= 1'b0;
      lat_addr  <= bus.cpu_addr;
      lat_we    <= bus.cpu_write_en;
      lat_wdata <= bus.cpu_wdata;
      consec    <= '0;
    end
  end

  // Step the burst word index and capture CPU read data as words complete.
  always_ff @(posedge clk) begin
    if (!rst) begin
      word_cnt <= '0;
      rdata_q  <= '0;
    end else begin
      if (grant_vga || grant_cpu)  word_cnt <= '0;
      else if (word_hit && owner_q) word_cnt <= word_cnt + 1'b1;
      if (word_hit && !owner_q && !lat_we)         rdata_q <= bus.dram_read_data;
      else if (timeout_hit && !owner_q && !lat_we) rdata_q <= TIMEOUT_RDATA;
    end
  end

  assign active             = (state == ST_ISSUE) || (state == ST_WAIT);
  assign bus.dram_start     = (state == ST_ISSUE);
  assign bus.dram_addr      = lat_addr;
  assign bus.dram_write_en  = active && !owner_q && lat_we;
  assign bus.dram_burst_en  = active && owner_q;
  assign bus.dram_data_in   = lat_wdata;
  assign bus.vga_word_valid = word_hit && owner_q;
  assign bus.vga_word_idx   = word_cnt;
  assign bus.vga_rdata      = bus.vga_word_valid ? bus.dram_read_data : 16'h0000;
  assign bus.vga_done       = (state == ST_DONE) && owner_q;
  assign bus.cpu_ack        = (state == ST_DONE) && !owner_q;
  assign bus.cpu_rdata      = rdata_q;
  assign bus.owner          = owner_q;
  assign bus.busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed and randomized bench for dram_arbiter. The bench
// plays both requesters and the DRAM controller. Grant order comes from a
// small request-level model of the VGA-priority/starvation rule.
module tb_dram_arbiter;
  localparam int BURST_LEN      = 32;
  localparam int VGA_MAX_CONSEC = 2;
  localparam int TIMEOUT_CYCLES = 255;

  logic clk = 1'b0;
  logic rst;

  int          checks = 0;
  int          fails  = 0;
  bit          exp_owner;
  logic [15:0] exp_cpu_rdata;
  int          vga_streak;
  bit          cpu_pending;
  bit          vga_pending;
  bit          win;
  int          to_cycles;
  bit          exp_order [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  dram_arbiter_if bus ();

  dram_arbiter #(
    .BURST_LEN      (BURST_LEN),
    .VGA_MAX_CONSEC (VGA_MAX_CONSEC),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_cpu_vga"}, {bus.cpu_ack, bus.cpu_rdata, bus.vga_word_valid,
                bus.vga_word_idx, bus.vga_rdata, bus.vga_done}, '0);
    checkOutput({tag, "_dram_misc"}, {bus.dram_start, bus.dram_addr, bus.dram_write_en,
                bus.dram_burst_en, bus.dram_data_in, bus.owner, bus.busy, bus.timeout_err}, '0);
  endtask

  task automatic applyStimulus(input bit cpu_r, input logic [24:0] cpu_a, input bit cpu_we,
                               input logic [15:0] cpu_d, input bit vga_r, input logic [24:0] vga_a);
    bus.cpu_req      = cpu_r;
    bus.cpu_addr     = cpu_a;
    bus.cpu_write_en = cpu_we;
    bus.cpu_wdata    = cpu_d;
    bus.vga_req      = vga_r;
    bus.vga_addr     = vga_a;
  endtask

  // VGA wins unless the CPU is waiting and VGA already had its quota in a row.
  function automatic bit modelPick(input bit cpu_p, input bit vga_p);
    bit v;
    v = vga_p && (!cpu_p || (vga_streak < VGA_MAX_CONSEC));
    if (v && cpu_p) vga_streak++;
    else            vga_streak = 0;
    return v;
  endfunction

  // Runs one granted transaction starting in its IDLE cycle; returns in the next IDLE cycle.
  task automatic serveOne(input bit is_vga, input int gap_sel, input int data_sel);
    logic [24:0] addr;
    logic        we;
    logic [15:0] wd;
    logic [15:0] d;
    int          words;
    int          gap;
    addr  = is_vga ? bus.vga_addr : bus.cpu_addr;
    we    = is_vga ? 1'b0 : bus.cpu_write_en;
    wd    = bus.cpu_wdata;
    words = is_vga ? BURST_LEN : 1;
    d     = '0;
    bus.dram_data_ready = 1'($urandom_range(0, 1));
    bus.dram_read_data  = 16'($urandom);
    @(negedge clk);
    checkOutput("idle_busy", bus.busy, 1'b0);
    checkOutput("idle_owner", bus.owner, exp_owner);
    checkOutput("idle_cpu_rdata", bus.cpu_rdata, exp_cpu_rdata);
    checkOutput("idle_pulses", {bus.cpu_ack, bus.vga_done, bus.dram_start, bus.vga_word_valid}, 4'b0);
    nextCycle();
    bus.dram_data_ready = 1'($urandom_range(0, 1));
    bus.dram_read_data  = 16'($urandom);
    @(negedge clk);
    checkOutput("issue_start", bus.dram_start, 1'b1);
    checkOutput("issue_addr", bus.dram_addr, addr);
    checkOutput("issue_we", bus.dram_write_en, we);
    checkOutput("issue_burst", bus.dram_burst_en, is_vga);
    checkOutput("issue_owner", bus.owner, is_vga);
    checkOutput("issue_valid", bus.vga_word_valid, 1'b0);
    if (!is_vga) checkOutput("issue_wdata", bus.dram_data_in, wd);
    exp_owner = is_vga;
    nextCycle();
    bus.dram_data_ready = 1'b0;
    for (int w = 0; w < words; w++) begin
      gap = (gap_sel >= 0) ? gap_sel : int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        checkOutput("wait_hold", {bus.busy, bus.dram_start, bus.vga_word_valid, bus.cpu_ack,
                    bus.vga_done, bus.dram_burst_en, bus.dram_write_en}, {1'b1, 4'b0, is_vga, we});
        nextCycle();
      end
      if (data_sel == -2)     d = 16'(w);
      else if (data_sel >= 0) d = 16'(data_sel);
      else                    d = 16'($urandom);
      bus.dram_data_ready = 1'b1;
      bus.dram_read_data  = d;
      @(negedge clk);
      checkOutput("word_valid", bus.vga_word_valid, is_vga);
      if (is_vga) begin
        checkOutput("word_idx", bus.vga_word_idx, w);
        checkOutput("word_data", bus.vga_rdata, d);
      end
      checkOutput("word_no_end", {bus.cpu_ack, bus.vga_done}, 2'b0);
      nextCycle();
      bus.dram_data_ready = 1'b0;
    end
    bus.dram_data_ready = 1'($urandom_range(0, 1));
    bus.dram_read_data  = 16'($urandom);
    if (!is_vga && !we) exp_cpu_rdata = d;
    @(negedge clk);
    checkOutput("done_pulses", {bus.cpu_ack, bus.vga_done}, {!is_vga, is_vga});
    checkOutput("done_ctrl", {bus.dram_start, bus.dram_burst_en, bus.dram_write_en, bus.vga_word_valid}, 4'b0);
    checkOutput("done_cpu_rdata", bus.cpu_rdata, exp_cpu_rdata);
    nextCycle();
    bus.dram_data_ready = 1'b0;
    if (is_vga) bus.vga_req = 1'b0;
    else        bus.cpu_req = 1'b0;
  endtask

  initial begin
    rst                 = 1'b0;
    bus.dram_data_ready = 1'b0;
    bus.dram_read_data  = '0;
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
    exp_owner     = 1'b0;
    exp_cpu_rdata = '0;
    vga_streak    = 0;
    cpu_pending   = 1'b0;
    vga_pending   = 1'b0;

    $display("[TB] reset");
    repeat (3) nextCycle();
    @(negedge clk);
    checkAllZero("reset");
    nextCycle();
    rst = 1'b1;

    $display("[TB] CPU write");
    applyStimulus(1'b1, 25'h00123, 1'b1, 16'hBEEF, 1'b0, '0);
    void'(modelPick(1'b1, 1'b0));
    serveOne(1'b0, 2, -1);

    $display("[TB] CPU read");
    applyStimulus(1'b1, 25'h00200, 1'b0, 16'h0000, 1'b0, '0);
    void'(modelPick(1'b1, 1'b0));
    serveOne(1'b0, -1, 16'h1234);

    $display("[TB] VGA burst");
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 25'h80000);
    void'(modelPick(1'b0, 1'b1));
    serveOne(1'b1, -1, -2);

    $display("[TB] starvation guard");
    applyStimulus(1'b1, 25'h01000, 1'b0, 16'h0000, 1'b1, 25'h00400);
    for (int i = 0; i < 6; i++) begin
      void'(modelPick(1'b1, 1'b1));
      serveOne(exp_order[i], 0, -1);
      if (i < 5) begin
        if (exp_order[i]) bus.vga_req = 1'b1;
        else              bus.cpu_req = 1'b1;
      end
    end
    bus.vga_req = 1'b0;

    $display("[TB] reset mid-burst");
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 25'h0ABCD);
    nextCycle();
    nextCycle();
    for (int w = 0; w <= 10; w++) begin
      bus.dram_data_ready = 1'b1;
      bus.dram_read_data  = 16'(w + 100);
      @(negedge clk);
      checkOutput("rst_pre_idx", bus.vga_word_idx, w);
      nextCycle();
    end
    bus.dram_data_ready = 1'b0;
    bus.vga_req         = 1'b0;
    bus.dram_read_data  = 16'hFFFF;
    rst                 = 1'b0;
    nextCycle();
    @(negedge clk);
    checkAllZero("rst_mid");
    nextCycle();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("rst_after_quiet", {bus.vga_done, bus.busy, bus.cpu_ack}, 3'b0);
      nextCycle();
    end
    exp_owner     = 1'b0;
    exp_cpu_rdata = '0;
    vga_streak    = 0;
    applyStimulus(1'b1, 25'h01FFF, 1'b0, 16'h0000, 1'b0, '0);
    void'(modelPick(1'b1, 1'b0));
    serveOne(1'b0, -1, -1);

    $display("[TB] randomized traffic");
    for (int r = 0; r < 40; r++) begin
      if (!cpu_pending && ($urandom_range(0, 1) == 1)) begin
        bus.cpu_req      = 1'b1;
        bus.cpu_addr     = 25'($urandom);
        bus.cpu_write_en = 1'($urandom);
        bus.cpu_wdata    = 16'($urandom);
        cpu_pending      = 1'b1;
      end
      if (!vga_pending && ($urandom_range(0, 2) == 0)) begin
        bus.vga_req  = 1'b1;
        bus.vga_addr = 25'($urandom);
        vga_pending  = 1'b1;
      end
      if (!cpu_pending && !vga_pending) begin
        bus.dram_data_ready = 1'($urandom);
        bus.dram_read_data  = 16'($urandom);
        @(negedge clk);
        checkOutput("idle_quiet", {bus.busy, bus.cpu_ack, bus.vga_done, bus.dram_start}, 4'b0);
        nextCycle();
        bus.dram_data_ready = 1'b0;
        continue;
      end
      win = modelPick(cpu_pending, vga_pending);
      serveOne(win, -1, -1);
      if (win) vga_pending = 1'b0;
      else     cpu_pending = 1'b0;
    end
    while (cpu_pending || vga_pending) begin
      win = modelPick(cpu_pending, vga_pending);
      serveOne(win, -1, -1);
      if (win) vga_pending = 1'b0;
      else     cpu_pending = 1'b0;
    end

`ifdef DRAM_ARB_TIMEOUT_EN
    $display("[TB] timeout");
    applyStimulus(1'b1, 25'h00321, 1'b0, 16'h0000, 1'b0, '0);
    nextCycle();
    to_cycles = 0;
    while (to_cycles < 400) begin
      @(negedge clk);
      if (bus.cpu_ack) break;
      nextCycle();
      to_cycles++;
    end
    checkOutput("to_ack_latency", to_cycles, 256);
    checkOutput("to_rdata", bus.cpu_rdata, 16'hDEAD);
    checkOutput("to_flag", bus.timeout_err, 1'b1);
    nextCycle();
    bus.cpu_req = 1'b0;
    repeat (3) nextCycle();
    @(negedge clk);
    checkOutput("to_sticky", bus.timeout_err, 1'b1);
    nextCycle();
    rst = 1'b0;
    nextCycle();
    @(negedge clk);
    checkOutput("to_cleared", bus.timeout_err, 1'b0);
    nextCycle();
    rst = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Shares the single SDRAM controller port between two requesters:
  - the CPU memory-map path: single-word reads and writes;
  - the VGA line fetcher: BURST_LEN-word read bursts that fill the scanline buffer.
- Sits between the requesters and the DRAM controller.
- Sequences each transaction: start strobe, wait for data ready, return data.
- Fixed VGA priority with a starvation guard for the CPU.

Parameters:
BURST_LEN, 32, words per VGA burst (a power of two, 2..32)
VGA_MAX_CONSEC, 2, back-to-back VGA grants allowed while the CPU is pending
TIMEOUT_CYCLES, 255, WAIT-state cycle limit (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
cpu_req  in  1  CPU request level; held until cpu_ack
cpu_addr  in  25  CPU word address
cpu_write_en  in  1  1 = write, 0 = read
cpu_wdata  in  16  CPU write data
cpu_ack  out  1  one-cycle pulse: CPU transaction complete
cpu_rdata  out  16  CPU read data; valid from the cpu_ack cycle, held until the next CPU ack
vga_req  in  1  VGA burst request level; held until vga_done
vga_addr  in  25  VGA burst base word address
vga_word_valid  out  1  one-cycle pulse per burst word
vga_word_idx  out  5  index of the current burst word, 0..BURST_LEN-1
vga_rdata  out  16  burst word data, qualified by vga_word_valid
vga_done  out  1  one-cycle pulse after the last burst word
dram_start  out  1  one-cycle transaction start strobe to the controller
dram_addr  out  25  controller address
dram_write_en  out  1  controller write enable
dram_burst_en  out  1  controller burst mode
dram_data_in  out  16  controller write data
dram_read_data  in  16  controller read data
dram_data_ready  in  1  one-cycle pulse per completed word
owner  out  1  0 = CPU, 1 = VGA; the current or last grant
busy  out  1  high in every state except IDLE
timeout_err  out  1  sticky timeout flag (optional feature only)

Behaviour:
- Reset (rst low at a clk edge):
  - state goes to IDLE; any in-flight transaction is discarded.
  - No ack or done pulse is produced for the discarded transaction.
  - Reset values: every output 0; consecutive-VGA counter 0; word counter 0.
- States and transitions:
  - IDLE: arbitrate on the requests sampled this cycle.
    - If vga_req=1 and (cpu_req=0 or consec<VGA_MAX_CONSEC), grant VGA; increment consec if cpu_req=1, otherwise clear consec.
    - Else if cpu_req=1, grant CPU and clear consec.
    - On a grant, latch address, write_en and wdata, then go to ISSUE.
  - ISSUE (1 cycle):
    - dram_start=1 and dram_addr=latched address.
    - CPU grant: dram_write_en=latched write_en, dram_data_in=latched wdata.
    - VGA grant: dram_burst_en=1, dram_write_en=0.
    - Go to WAIT.
  - WAIT, CPU grant: on dram_data_ready, capture dram_read_data (reads only), then go to DONE.
  - WAIT, VGA grant: on each dram_data_ready:
    - vga_word_valid=1 in the same cycle;
    - vga_rdata=dram_read_data (combinational pass-through);
    - vga_word_idx=word counter, then the counter increments.
    - On the BURST_LEN-th pulse, go to DONE.
  - DONE (1 cycle):
    - Pulse cpu_ack or vga_done, matching owner.
    - Go to IDLE; the next request is sampled in IDLE one cycle later.
- Handshake:
  - A requester deasserts req in the cycle after it sees ack/done.
  - A req still high in IDLE counts as a new request.
  - Request inputs are ignored outside IDLE; latched values are used for the whole transaction.
- Latency:
  - CPU: request seen in IDLE at cycle 0, dram_start at cycle 1, ready at cycle N, cpu_ack at cycle N+1.
  - Minimum turnaround from ack to the next dram_start is 2 cycles.
- Widths and counters:
  - The word counter is 5 bits and resets to 0 at every grant.
  - dram_burst_en and dram_write_en are held through WAIT and drop to 0 in DONE.
- Boundary cases:
  - dram_data_ready outside WAIT is ignored.
  - A dram_data_ready pulse in the ISSUE cycle is ignored.
  - Both requests rise in the same IDLE cycle: VGA wins unless the guard has tripped.

Optional Feature:
- Macro: DRAM_ARB_TIMEOUT_EN.
- With the macro defined:
  - A WAIT-cycle counter runs.
  - On reaching TIMEOUT_CYCLES without completing, go to DONE and set timeout_err=1 (sticky until reset).
  - A timed-out CPU read returns cpu_rdata=16'hDEAD.
  - For a timed-out VGA burst, vga_done pulses and the missing words are not produced.
- Without the macro:
  - WAIT holds indefinitely.
  - timeout_err is tied to 0.

Test Plan:
- CPU write: cpu_req with addr=0x00123, wdata=0xBEEF, write_en=1; controller ready 3 cycles after start -> dram_start for 1 cycle with dram_addr=0x00123, dram_write_en=1, dram_data_in=0xBEEF; cpu_ack exactly 1 cycle after ready.
- CPU read: addr=0x00200, ready carrying 0x1234 -> cpu_rdata=0x1234 at cpu_ack; dram_burst_en=0 throughout.
- VGA burst: vga_addr=0x80000, 32 ready pulses carrying 0..31 -> 32 vga_word_valid pulses with idx=data; dram_burst_en=1 through WAIT; a single vga_done after idx 31.
- Starvation guard: vga_req and cpu_req held high, VGA_MAX_CONSEC=2 -> grant order VGA, VGA, CPU, VGA, VGA, CPU, checked via owner at each grant.
- Reset mid-burst: rst low after word 10 -> no vga_done; all outputs 0; after release, a new cpu_req is granted normally.
- Timeout (DRAM_ARB_TIMEOUT_EN defined): CPU read with no ready -> cpu_ack at WAIT cycle 255, cpu_rdata=0xDEAD, timeout_err=1 until reset.
